pixel_unpack: RTL and testbench

PIXEL_UNPACK -- requirements
Module: pixel_unpack

---
 rtl/pixel_unpack_pkg.sv | 21 ++
 rtl/pixel_unpack.sv | 117 +++++++++++
 tb/tb_pixel_unpack.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_unpack_pkg.sv
// Shared widths and types for the packed-word to pixel-stream unpacker.
// One 32-bit word carries four 8-bit pixels, lane 0 in the low byte.
package pixel_unpack_pkg;

   localparam int unsigned PIX_W   = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned LANES   = 4;
   localparam int unsigned COORD_W = 16;

   typedef logic [PIX_W-1:0]         pix_t;
   typedef logic [WORD_W-1:0]        word_t;
   typedef logic [COORD_W-1:0]       coord_t;
   typedef logic [$clog2(LANES)-1:0] lane_t;

   localparam lane_t LANE_LAST = lane_t'(LANES - 1);

   function automatic pix_t lane_pix(input word_t w, input lane_t l);
      return w[PIX_W*int'(l) +: PIX_W];
   endfunction

endpackage

// File: rtl/pixel_unpack.sv
// Unpacks 32-bit words into an 8-bit pixel stream with frame coordinates,
// start-of-frame / end-of-line flags, a frame-done pulse and a sticky tlast check.
module pixel_unpack
   import pixel_unpack_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WORD_W-1:0]  s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   output logic [PIX_W-1:0]   m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tuser,
   output logic               m_axis_tlast,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               frame_done,
   output logic               err_tlast
);

   // A frame must end exactly on a word boundary for the tlast check to make sense.
   if ((IMG_WIDTH * IMG_HEIGHT) % LANES != 0) begin : g_bad_geometry
      $error("pixel_unpack: IMG_WIDTH*IMG_HEIGHT must be a multiple of %0d", LANES);
   end

   localparam coord_t X_LAST = coord_t'(IMG_WIDTH - 1);
   localparam coord_t Y_LAST = coord_t'(IMG_HEIGHT - 1);

   word_t  word_q, word_d;
   logic   valid_q, valid_d;
   logic   wlast_q, wlast_d;
   lane_t  lane_q, lane_d;
   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   done_q, done_d;
   logic   err_q, err_d;

   logic out_hs, in_hs, x_last, frame_last;

   assign out_hs     = valid_q && m_axis_tready;
   assign s_axis_tready = !valid_q || (lane_q == LANE_LAST && m_axis_tready);
   assign in_hs      = s_axis_tvalid && s_axis_tready;
   assign x_last     = (x_q == X_LAST);
   assign frame_last = x_last && (y_q == Y_LAST);

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      wlast_d = wlast_q;
      lane_d  = lane_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      done_d  = out_hs && frame_last;

      if (out_hs) begin
         if (lane_q == LANE_LAST) begin
            valid_d = 1'b0;
            if (wlast_q != frame_last) err_d = 1'b1;
         end else begin
            lane_d = lane_t'(lane_q + 1'b1);
         end

         if (x_last) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : coord_t'(y_q + 1'b1);
         end else begin
            x_d = coord_t'(x_q + 1'b1);
         end
      end

      // A word accepted during lane 3's output handshake overrides the clear above.
      if (in_hs) begin
         word_d  = s_axis_tdata;
         wlast_d = s_axis_tlast;
         valid_d = 1'b1;
         lane_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         wlast_q <= 1'b0;
         lane_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         wlast_q <= wlast_d;
         lane_q  <= lane_d;
         x_q     <= x_d;
         y_q     <= y_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign m_axis_tvalid = valid_q;
   assign m_axis_tdata  = lane_pix(word_q, lane_q);
   assign m_axis_tuser  = (x_q == '0) && (y_q == '0);
   assign m_axis_tlast  = x_last;
   assign pix_x         = x_q;
   assign pix_y         = y_q;
   assign frame_done    = done_q;
   assign err_tlast     = err_q;

endmodule

// File: tb/tb_pixel_unpack.sv
// Randomised self-checking bench for pixel_unpack (8x2 image) against a
// byte-queue reference model that tracks pixel index, frame position and tlast errors.
module tb_pixel_unpack;
   import pixel_unpack_pkg::*;

   localparam int unsigned W     = 8;
   localparam int unsigned H     = 2;
   localparam int unsigned FRAME = W * H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        m_ready = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
   logic [15:0] pix_x, pix_y;
   logic        frame_done, err_tlast;

   pixel_unpack #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .err_tlast(err_tlast)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [7:0] b; bit l3; bit tl; } ent_t;
   ent_t        q[$];
   int unsigned n = 0, hs_count = 0, fd_count = 0, run = 0, last_run = 0;
   bit          err_exp = 0, fd_exp = 0;

   // Reference model: every accepted word becomes four queued bytes; pixel n of the
   // stream sits at (n % W, (n / W) % H).
   always @(negedge clk) begin
      ent_t        e;
      int unsigned ex, ey;
      if (rst) begin
         q.delete();
         n = 0; err_exp = 0; fd_exp = 0; run = 0;
      end else begin
         chk("s_tready", s_axis_tready, (q.size() == 0) || (q.size() == 1 && m_ready));
         chk("m_tvalid", m_axis_tvalid, q.size() != 0);
         chk("frame_done", frame_done, fd_exp);
         chk("err_tlast", err_tlast, err_exp);
         if (frame_done) fd_count++;
         fd_exp = 0;
         if (q.size() != 0) begin
            ex = n % W;
            ey = (n / W) % H;
            chk("m_tdata", m_axis_tdata, q[0].b);
            chk("pix_x", pix_x, ex);
            chk("pix_y", pix_y, ey);
            chk("m_tuser", m_axis_tuser, ex == 0 && ey == 0);
            chk("m_tlast", m_axis_tlast, ex == W - 1);
            if (m_ready) begin
               e = q.pop_front();
               if (e.l3 && (e.tl != (n % FRAME == FRAME - 1))) err_exp = 1;
               fd_exp = (n % FRAME == FRAME - 1);
               n++; hs_count++; run++;
            end else begin
               if (run != 0) last_run = run;
               run = 0;
            end
         end else begin
            if (run != 0) last_run = run;
            run = 0;
         end
         if (s_tvalid && s_axis_tready) begin
            for (int i = 0; i < 4; i++) begin
               e.b  = s_tdata[8*i +: 8];
               e.l3 = (i == 3);
               e.tl = s_tlast;
               q.push_back(e);
            end
         end
      end
   end

   // Output-side ready pattern: 0 = always, 1 = two high / two low, 2 = random.
   int unsigned mode = 0, gap_max = 0;
   initial begin
      int unsigned cyc = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 4) < 2;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_word(input logic [31:0] d, input logic l);
      logic        acc = 1'b0;
      int unsigned k = 0, gap;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
      while (!acc && k < 300) begin
         @(negedge clk); acc = s_axis_tready;
         @(posedge clk); #1;
         k++;
      end
      if (!acc) chk("send_timeout", 0, 1);
      gap = (gap_max != 0) ? $urandom_range(0, gap_max) : 0;
      if (gap != 0) begin
         s_tvalid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input bit counting, input int unsigned tlast_word);
      logic [31:0] d;
      for (int unsigned w = 0; w < FRAME / 4; w++) begin
         d = counting ? {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)} : $urandom;
         send_word(d, w == tlast_word);
      end
   endtask

   task automatic drain();
      int unsigned k = 0;
      s_tvalid = 1'b0;
      while (q.size() != 0 && k < 500) begin @(posedge clk); k++; end
      repeat (3) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_s_tready", s_axis_tready, 1);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tuser", m_axis_tuser, 1);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err_tlast", err_tlast, 0);
   endtask

   initial begin
      int unsigned fd0, base, k;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs();

      // Counting frame, sink always ready.
      mode = 0; gap_max = 0; fd0 = fd_count;
      send_frame(1, 3); drain();
      chk("t1_frames", fd_count - fd0, 1);
      chk("t1_err", err_tlast, 0);

      // Same frame, sink toggling 2 high / 2 low.
      mode = 1; fd0 = fd_count;
      send_frame(1, 3); drain();
      chk("t2_frames", fd_count - fd0, 1);

      // Two frames back-to-back with valid held: one unbroken 32-pixel run.
      mode = 0;
      send_frame(0, 3); send_frame(0, 3); drain();
      chk("t3_run", last_run, 2 * FRAME);

      // tlast on the second word: sticky error, pixel flow unchanged.
      fd0 = fd_count;
      send_frame(1, 1); drain();
      chk("t4_err", err_tlast, 1);
      send_frame(0, 3); drain();
      chk("t4_err_sticky", err_tlast, 1);
      chk("t4_frames", fd_count - fd0, 2);

      // Reset after five output pixels.
      base = hs_count;
      send_word(32'hA3A2A1A0, 1'b0);
      send_word(32'hA7A6A5A4, 1'b0);
      s_tvalid = 1'b0;
      k = 0;
      while (hs_count < base + 5 && k < 200) begin @(posedge clk); k++; end
      #1;
      chk("t5_wait", k < 200, 1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(1, 3); drain();
      chk("t5_err", err_tlast, 0);

      // Random data, random gaps, random sink ready.
      mode = 2; gap_max = 3; fd0 = fd_count;
      repeat (3) send_frame(0, 3);
      drain();
      chk("t6_frames", fd_count - fd0, 3);
      chk("t6_err", err_tlast, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
